// File: rtl/regfile_mp_sb_pkg.sv
// Shared defaults for the multi-port register file and its write arbiter.
package regfile_mp_sb_pkg;

    localparam int DEF_XLEN = 32;
    localparam int DEF_NREG = 32;
    localparam int DEF_NRD  = 2;
    localparam int DEF_NWR  = 2;

endpackage

// File: rtl/regfile_mp_sb_wr_arb.sv
// Write-port arbiter: for every register, reports whether any enabled port
// writes it this cycle and which data wins (highest-numbered port wins).
// Index 0 never produces a hit, so register 0 can never be written or bypassed.
module regfile_mp_sb_wr_arb
    import regfile_mp_sb_pkg::*;
#(
    parameter int  XLEN = DEF_XLEN,
    parameter int  NREG = DEF_NREG,
    parameter int  NWR  = DEF_NWR,
    localparam int AW   = $clog2(NREG)
) (
    input  logic [NWR-1:0]       wen,
    input  logic [NWR*AW-1:0]    wr_idx,
    input  logic [NWR*XLEN-1:0]  wr_data,
    output logic [NREG-1:0]      write_hit,
    output logic [NREG*XLEN-1:0] win_data
);

    // Scan ports low to high so a later (higher) port overrides an earlier match
    always_comb begin
        write_hit = '0;
        win_data  = '0;
        for (int p = 0; p < NWR; p++) begin
            if (wen[p] && (wr_idx[p*AW +: AW] != '0)) begin
                write_hit[wr_idx[p*AW +: AW]]               = 1'b1;
                win_data[wr_idx[p*AW +: AW]*XLEN +: XLEN]   = wr_data[p*XLEN +: XLEN];
            end
        end
    end

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port integer register file with per-register busy scoreboard and
// optional same-cycle write-to-read bypass. Register 0 reads as zero and is
// never busy.
module regfile_mp_sb
    import regfile_mp_sb_pkg::*;
#(
    parameter int  XLEN   = DEF_XLEN,
    parameter int  NREG   = DEF_NREG,
    parameter int  NRD    = DEF_NRD,
    parameter int  NWR    = DEF_NWR,
    parameter int  BYPASS = 1,
    localparam int AW     = $clog2(NREG)
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [NWR-1:0]       wen,
    input  logic [NWR*AW-1:0]    wr_idx,
    input  logic [NWR*XLEN-1:0]  wr_data,
    input  logic [NRD*AW-1:0]    rd_idx,
    output logic [NRD*XLEN-1:0]  rd_data,
    output logic [NRD-1:0]       rd_busy,
    input  logic                 sb_set,
    input  logic [AW-1:0]        sb_idx,
    output logic [NREG-1:0]      busy_vec
);

    logic [NREG-1:0]      write_hit;
    logic [NREG*XLEN-1:0] win_data;
    logic [XLEN-1:0]      regs [NREG];
    logic [NREG-1:0]      busy_q;
    logic [NREG-1:0]      busy_d;

    regfile_mp_sb_wr_arb #(
        .XLEN (XLEN),
        .NREG (NREG),
        .NWR  (NWR)
    ) u_wr_arb (
        .wen       (wen),
        .wr_idx    (wr_idx),
        .wr_data   (wr_data),
        .write_hit (write_hit),
        .win_data  (win_data)
    );

    // Register storage: each register loads the winning write data when hit;
    // write_hit[0] is never set, so register 0 stays at its reset value of 0
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (write_hit[i]) begin
                    regs[i] <= win_data[i*XLEN +: XLEN];
                end
            end
        end
    end

    // Scoreboard next state: a new producer (set) supersedes a retiring one (write)
    always_comb begin
        busy_d = '0;
        for (int i = 1; i < NREG; i++) begin
            busy_d[i] = (sb_set && (sb_idx == AW'(i))) || (busy_q[i] && !write_hit[i]);
        end
    end

    // Scoreboard state register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_vec = busy_q;

    // Read ports: optional forwarding of the winning writer; a register being
    // written this cycle is reported available when forwarding is enabled.
    // Reads are forced to zero while reset is asserted so bypass cannot leak.
    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0] idx;
        logic          byp;

        assign idx = rd_idx[k*AW +: AW];
        assign byp = (BYPASS != 0) && write_hit[idx];

        assign rd_data[k*XLEN +: XLEN] = !rstn ? '0 :
                                         byp   ? win_data[idx*XLEN +: XLEN] :
                                                 regs[idx];
        assign rd_busy[k] = busy_q[idx] && !byp;
    end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Self-checking bench for regfile_mp_sb: one BYPASS=1 and one BYPASS=0
// instance share all inputs and are compared against an array-based model.
module tb_regfile_mp_sb;

    localparam int XL = 32;
    localparam int NR = 32;
    localparam int AL = 5;

    logic            clk;
    logic            rstn;
    logic [1:0]      wen;
    logic [2*AL-1:0] wr_idx;
    logic [2*XL-1:0] wr_data;
    logic [2*AL-1:0] rd_idx;
    logic            sb_set;
    logic [AL-1:0]   sb_idx;

    logic [2*XL-1:0] rd_data_b1, rd_data_b0;
    logic [1:0]      rd_busy_b1, rd_busy_b0;
    logic [NR-1:0]   busy_vec_b1, busy_vec_b0;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [XL-1:0] mem [NR];
    logic [NR-1:0] mbusy;

    regfile_mp_sb #(.XLEN(XL), .NREG(NR), .NRD(2), .NWR(2), .BYPASS(1)) dut_b1 (
        .clk(clk), .rstn(rstn), .wen(wen), .wr_idx(wr_idx), .wr_data(wr_data),
        .rd_idx(rd_idx), .rd_data(rd_data_b1), .rd_busy(rd_busy_b1),
        .sb_set(sb_set), .sb_idx(sb_idx), .busy_vec(busy_vec_b1)
    );

    regfile_mp_sb #(.XLEN(XL), .NREG(NR), .NRD(2), .NWR(2), .BYPASS(0)) dut_b0 (
        .clk(clk), .rstn(rstn), .wen(wen), .wr_idx(wr_idx), .wr_data(wr_data),
        .rd_idx(rd_idx), .rd_data(rd_data_b0), .rd_busy(rd_busy_b0),
        .sb_set(sb_set), .sb_idx(sb_idx), .busy_vec(busy_vec_b0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [XL-1:0] exp_rd(input int k, input bit byp);
        logic [AL-1:0] idx;
        idx = rd_idx[k*AL +: AL];
        if (!rstn) return '0;
        if (byp && idx != 0) begin
            for (int p = 1; p >= 0; p--) begin
                if (wen[p] && wr_idx[p*AL +: AL] == idx) return wr_data[p*XL +: XL];
            end
        end
        return mem[idx];
    endfunction

    function automatic logic exp_busy(input int k, input bit byp);
        logic [AL-1:0] idx;
        idx = rd_idx[k*AL +: AL];
        if (byp && idx != 0) begin
            for (int p = 0; p < 2; p++) begin
                if (wen[p] && wr_idx[p*AL +: AL] == idx) return 1'b0;
            end
        end
        return mbusy[idx];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NR; i++) mem[i] = '0;
        mbusy = '0;
    endtask

    // Advance the model by one clock using the inputs held across the edge
    task automatic model_update();
        logic [NR-1:0] hit;
        hit = '0;
        for (int p = 0; p < 2; p++) begin
            if (wen[p] && wr_idx[p*AL +: AL] != 0) begin
                mem[wr_idx[p*AL +: AL]] = wr_data[p*XL +: XL];
                hit[wr_idx[p*AL +: AL]] = 1'b1;
            end
        end
        mbusy = mbusy & ~hit;
        if (sb_set && sb_idx != 0) mbusy[sb_idx] = 1'b1;
    endtask

    task automatic check_all();
        for (int k = 0; k < 2; k++) begin
            check($sformatf("rd_data_b1[%0d]", k), rd_data_b1[k*XL +: XL], exp_rd(k, 1'b1));
            check($sformatf("rd_data_b0[%0d]", k), rd_data_b0[k*XL +: XL], exp_rd(k, 1'b0));
            check($sformatf("rd_busy_b1[%0d]", k), rd_busy_b1[k], exp_busy(k, 1'b1));
            check($sformatf("rd_busy_b0[%0d]", k), rd_busy_b0[k], exp_busy(k, 1'b0));
        end
        check("busy_vec_b1", busy_vec_b1, mbusy);
        check("busy_vec_b0", busy_vec_b0, mbusy);
    endtask

    task automatic idle();
        wen = '0; wr_idx = '0; wr_data = '0; rd_idx = '0; sb_set = 1'b0; sb_idx = '0;
    endtask

    task automatic set_wr(input int p, input logic [AL-1:0] idx, input logic [XL-1:0] d);
        wen[p] = 1'b1;
        wr_idx[p*AL +: AL] = idx;
        wr_data[p*XL +: XL] = d;
    endtask

    task automatic set_rd(input int k, input logic [AL-1:0] idx);
        rd_idx[k*AL +: AL] = idx;
    endtask

    // Called in the low phase with inputs applied: check, clock, return at negedge
    task automatic step();
        #1;
        check_all();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    // Short asynchronous reset pulse entirely inside the low phase
    task automatic reset_pulse();
        idle();
        #1;
        rstn = 1'b0;
        #1;
        model_clear();
        check_all();
        check("async_rst_rd0", rd_data_b1[XL-1:0], '0);
        #1;
        rstn = 1'b1;
    endtask

    initial begin
        idle();
        rstn = 1'b0;
        model_clear();
        repeat (2) @(negedge clk);
        #1;
        check_all();
        rstn = 1'b1;
        @(negedge clk);

        // Reset: write r5 then pulse reset between edges
        set_wr(0, 5'd5, 32'hDEADBEEF);
        step();
        idle(); set_rd(0, 5'd5);
        #1;
        check("r5_written", rd_data_b1[XL-1:0], 32'hDEADBEEF);
        reset_pulse();
        set_rd(0, 5'd5);
        #1;
        check("r5_after_rst", rd_data_b1[XL-1:0], '0);
        step();

        // r0 protection
        idle();
        set_wr(0, 5'd0, 32'h1234); set_wr(1, 5'd0, 32'h5678);
        sb_set = 1'b1; sb_idx = 5'd0;
        step();
        idle();
        #1;
        check("r0_read_b1", rd_data_b1[XL-1:0], '0);
        check("r0_busy", {31'd0, busy_vec_b1[0]}, '0);
        step();

        // Write conflict and independent writes
        set_wr(0, 5'd7, 32'hAAAA); set_wr(1, 5'd7, 32'hBBBB);
        step();
        idle();
        set_wr(0, 5'd3, 32'h11); set_wr(1, 5'd4, 32'h22);
        step();
        idle(); set_rd(0, 5'd7); set_rd(1, 5'd3);
        #1;
        check("r7_conflict", rd_data_b1[XL-1:0], 32'hBBBB);
        check("r3_land", rd_data_b1[2*XL-1:XL], 32'h11);
        step();
        set_rd(0, 5'd4);
        #1;
        check("r4_land", rd_data_b0[XL-1:0], 32'h22);
        step();

        // Bypass
        idle(); set_wr(0, 5'd9, 32'h10);
        step();
        idle(); set_wr(1, 5'd9, 32'h99); set_rd(0, 5'd9);
        #1;
        check("byp1_same", rd_data_b1[XL-1:0], 32'h99);
        check("byp0_same", rd_data_b0[XL-1:0], 32'h10);
        step();
        idle(); set_rd(0, 5'd9);
        #1;
        check("byp0_next", rd_data_b0[XL-1:0], 32'h99);
        step();

        // Scoreboard set then retire of r12
        idle(); sb_set = 1'b1; sb_idx = 5'd12; set_rd(0, 5'd12);
        #1;
        check("sb_t_rdbusy", {31'd0, rd_busy_b1[0]}, '0);
        step();
        idle(); set_rd(0, 5'd12);
        #1;
        check("sb_t1_rdbusy", {31'd0, rd_busy_b1[0]}, 1);
        check("sb_t1_vec", {31'd0, busy_vec_b1[12]}, 1);
        step();
        step();
        set_wr(0, 5'd12, 32'hC0DE);
        #1;
        check("sb_t3_rdbusy_b1", {31'd0, rd_busy_b1[0]}, '0);
        check("sb_t3_rdbusy_b0", {31'd0, rd_busy_b0[0]}, 1);
        step();
        idle();
        #1;
        check("sb_t4_vec", {31'd0, busy_vec_b1[12]}, '0);
        step();

        // Set/clear collision on r12
        sb_set = 1'b1; sb_idx = 5'd12;
        step();
        idle(); set_wr(1, 5'd12, 32'h1); sb_set = 1'b1; sb_idx = 5'd12;
        step();
        idle();
        #1;
        check("coll_stays", {31'd0, busy_vec_b1[12]}, 1);
        set_wr(0, 5'd12, 32'h2);
        step();
        idle();
        #1;
        check("coll_clears", {31'd0, busy_vec_b1[12]}, '0);
        step();

        // Randomized traffic with small index range to provoke collisions
        for (int c = 0; c < 600; c++) begin
            idle();
            wen = 2'($urandom_range(0, 3));
            for (int p = 0; p < 2; p++) begin
                wr_idx[p*AL +: AL]  = AL'($urandom_range(0, 15));
                wr_data[p*XL +: XL] = $urandom;
            end
            for (int k = 0; k < 2; k++) begin
                if ($urandom_range(0, 2) == 0)
                    rd_idx[k*AL +: AL] = wr_idx[$urandom_range(0, 1)*AL +: AL];
                else
                    rd_idx[k*AL +: AL] = AL'($urandom_range(0, 15));
            end
            sb_set = ($urandom_range(0, 2) == 0);
            sb_idx = AL'($urandom_range(0, 15));
            if (c % 97 == 50) reset_pulse();
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
